// File: rtl/mc_pkg.sv
// ============================================================================
// mc_pkg : shared state encoding and decode constants for mc_control
// Rev 1.0
// ============================================================================
`default_nettype none

package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_RTYPEEX = 4'd7,
    S_RTYPEWB = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_HALT    = 4'd13
  } state_e;

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2b;

  localparam logic [5:0] c_FN_ADD = 6'h20;
  localparam logic [5:0] c_FN_SUB = 6'h22;
  localparam logic [5:0] c_FN_AND = 6'h24;
  localparam logic [5:0] c_FN_OR  = 6'h25;
  localparam logic [5:0] c_FN_SLT = 6'h2a;

  localparam logic [2:0] c_ALU_AND = 3'b000;
  localparam logic [2:0] c_ALU_OR  = 3'b001;
  localparam logic [2:0] c_ALU_ADD = 3'b010;
  localparam logic [2:0] c_ALU_SUB = 3'b110;
  localparam logic [2:0] c_ALU_SLT = 3'b111;

  localparam logic [1:0] c_SRCB_REGB  = 2'b00;
  localparam logic [1:0] c_SRCB_FOUR  = 2'b01;
  localparam logic [1:0] c_SRCB_IMM   = 2'b10;
  localparam logic [1:0] c_SRCB_IMMSH = 2'b11;

  localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
  localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mc_alu_dec.sv
// ============================================================================
// mc_alu_dec : R-type funct to ALU operation decoder with legality flag
// Rev 1.0
// ============================================================================
`default_nettype none

module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       valid
);

  always_comb begin
    alu_op = c_ALU_ADD;
    valid  = 1'b1;
    case (funct)
      c_FN_AND: alu_op = c_ALU_AND;
      c_FN_OR:  alu_op = c_ALU_OR;
      c_FN_ADD: alu_op = c_ALU_ADD;
      c_FN_SUB: alu_op = c_ALU_SUB;
      c_FN_SLT: alu_op = c_ALU_SLT;
      default:  valid  = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control.sv
// ============================================================================
// mc_control : multi-cycle MIPS-subset control FSM with retire counter
// Rev 1.0
// ============================================================================
`default_nettype none

module mc_control
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem2reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic        illegal,
  output logic        busy,
  output logic [31:0] retired
);

  state_e      state_q, state_d;
  logic [31:0] retired_q, retired_d;
  logic        illegal_q, illegal_d;
  logic        retire;
  logic [2:0]  dec_alu_op;
  logic        dec_valid;

  mc_alu_dec u_alu_dec (
    .funct  (funct),
    .alu_op (dec_alu_op),
    .valid  (dec_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      retired_q <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    pc_en     = 1'b0;
    iord      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_dst   = 1'b0;
    mem2reg   = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = c_SRCB_REGB;
    alu_op    = c_ALU_AND;
    pc_src    = c_PCSRC_ALU;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = c_SRCB_FOUR;
        alu_op    = c_ALU_ADD;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Speculative branch target is computed here so BEQEX can use ALUOut
        alu_src_b = c_SRCB_IMMSH;
        alu_op    = c_ALU_ADD;
        case (opcode)
          c_OP_LW, c_OP_SW: state_d = S_MEMADR;
          c_OP_ADDI:        state_d = S_ADDIEX;
          c_OP_BEQ:         state_d = S_BEQEX;
          c_OP_J:           state_d = S_JEX;
          c_OP_RTYPE: begin
            if (dec_valid) begin
              state_d = S_RTYPEEX;
            end else begin
              state_d   = S_HALT;
              illegal_d = 1'b1;
            end
          end
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = c_SRCB_IMM;
        alu_op    = c_ALU_ADD;
        state_d   = (opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem2reg   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        retire    = mem_ready;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_src_b = c_SRCB_REGB;
        alu_op    = dec_alu_op;
        state_d   = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = c_SRCB_IMM;
        alu_op    = c_ALU_ADD;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a = 1'b1;
        alu_src_b = c_SRCB_REGB;
        alu_op    = c_ALU_SUB;
        pc_src    = c_PCSRC_ALUOUT;
        pc_en     = zero;
        retire    = 1'b1;
      end
      S_JEX: begin
        pc_src = c_PCSRC_JUMP;
        pc_en  = 1'b1;
        retire = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // run is only consulted at instruction boundaries
    if (retire) state_d = run ? S_FETCH : S_IDLE;
  end

  assign retired_d = retire ? retired_q + 32'd1 : retired_q;
  assign retired   = retired_q;
  assign illegal   = illegal_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_mc_control.sv
// ============================================================================
// tb_mc_control : directed table-driven bench for mc_control
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mc_control;

  logic        clk, rst, run, zero, mem_ready;
  logic [5:0]  opcode, funct;
  logic        pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem2reg;
  logic        reg_write, alu_src_a, illegal, busy;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_op;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  mc_control dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem2reg(mem2reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .illegal(illegal), .busy(busy), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        mr;
    logic [17:0] exp;
    logic [31:0] ret;
  } vec_t;

  vec_t tbl[64];
  int   n = 0;

  // Output bundle bit order: pc_en iord mem_read mem_write ir_write reg_dst
  // mem2reg reg_write alu_src_a alu_src_b[1:0] alu_op[2:0] pc_src[1:0] illegal busy
  function automatic logic [17:0] mk(input logic pce, io, mr, mw, irw, rd, m2r, rw, a,
                                     input logic [1:0] b, input logic [2:0] op,
                                     input logic [1:0] pcs, input logic ill, bsy);
    return {pce, io, mr, mw, irw, rd, m2r, rw, a, b, op, pcs, ill, bsy};
  endfunction

  function automatic logic [17:0] outs();
    return {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem2reg, reg_write,
            alu_src_a, alu_src_b, alu_op, pc_src, illegal, busy};
  endfunction

  logic [17:0] O_IDLE, O_FR, O_FW, O_DEC, O_MADR, O_MRD, O_MWB, O_MWR, O_RWB;
  logic [17:0] O_AWB, O_BQ1, O_BQ0, O_J, O_HALT;

  function automatic logic [17:0] o_rex(input logic [2:0] op);
    return mk(0,0,0,0,0,0,0,0,1,2'b00,op,2'b00,0,1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic mr, input logic [17:0] e, input logic [31:0] rt);
    tbl[n] = '{r, op, fn, z, mr, e, rt};
    n++;
  endtask

  task automatic drive(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic mr);
    run = r; opcode = op; funct = fn; zero = z; mem_ready = mr;
  endtask

  // Called at a negedge: apply, settle, then advance to the next negedge
  task automatic step_chk(input string name, input logic r, input logic [5:0] op,
                          input logic [5:0] fn, input logic z, input logic mr,
                          input logic [17:0] e);
    drive(r, op, fn, z, mr);
    #1;
    check(name, {14'd0, outs()}, {14'd0, e});
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 6'h00, 6'h00, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic add_rtype(input logic [5:0] fn, input logic [2:0] op, input logic [31:0] rt);
    add(1, 6'h00, fn, 0, 1, O_FR,      rt);
    add(1, 6'h00, fn, 0, 1, O_DEC,     rt);
    add(1, 6'h00, fn, 0, 1, o_rex(op), rt);
    add(1, 6'h00, fn, 0, 1, O_RWB,     rt);
  endtask

  initial begin
    O_IDLE = '0;
    O_FR   = mk(1,0,1,0,1,0,0,0,0,2'b01,3'b010,2'b00,0,1);
    O_FW   = mk(0,0,1,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,1);
    O_DEC  = mk(0,0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,1);
    O_MADR = mk(0,0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,1);
    O_MRD  = mk(0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,1);
    O_MWB  = mk(0,0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0,1);
    O_MWR  = mk(0,1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,1);
    O_RWB  = mk(0,0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0,1);
    O_AWB  = mk(0,0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0,1);
    O_BQ1  = mk(1,0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0,1);
    O_BQ0  = mk(0,0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0,1);
    O_J    = mk(1,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,0,1);
    O_HALT = mk(0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,1,0);

    // Continuous program run from IDLE
    add(0, 6'h00, 6'h00, 0, 1, O_IDLE, 0);
    add(1, 6'h00, 6'h00, 0, 1, O_IDLE, 0);
    // lw, no wait: 5 cycles
    add(1, 6'h23, 6'h00, 0, 1, O_FR,   0);
    add(1, 6'h23, 6'h00, 0, 1, O_DEC,  0);
    add(1, 6'h23, 6'h00, 0, 1, O_MADR, 0);
    add(1, 6'h23, 6'h00, 0, 1, O_MRD,  0);
    add(1, 6'h23, 6'h00, 0, 1, O_MWB,  0);
    // slt with two fetch wait cycles
    add(1, 6'h00, 6'h2a, 0, 0, O_FW,   1);
    add(1, 6'h00, 6'h2a, 0, 0, O_FW,   1);
    add(1, 6'h00, 6'h2a, 0, 1, O_FR,   1);
    add(1, 6'h00, 6'h2a, 0, 1, O_DEC,  1);
    add(1, 6'h00, 6'h2a, 0, 1, o_rex(3'b111), 1);
    add(1, 6'h00, 6'h2a, 0, 1, O_RWB,  1);
    // beq taken, then not taken
    add(1, 6'h04, 6'h00, 1, 1, O_FR,   2);
    add(1, 6'h04, 6'h00, 1, 1, O_DEC,  2);
    add(1, 6'h04, 6'h00, 1, 1, O_BQ1,  2);
    add(1, 6'h04, 6'h00, 0, 1, O_FR,   3);
    add(1, 6'h04, 6'h00, 0, 1, O_DEC,  3);
    add(1, 6'h04, 6'h00, 0, 1, O_BQ0,  3);
    // addi
    add(1, 6'h08, 6'h00, 0, 1, O_FR,   4);
    add(1, 6'h08, 6'h00, 0, 1, O_DEC,  4);
    add(1, 6'h08, 6'h00, 0, 1, O_MADR, 4);
    add(1, 6'h08, 6'h00, 0, 1, O_AWB,  4);
    // j
    add(1, 6'h02, 6'h00, 0, 1, O_FR,   5);
    add(1, 6'h02, 6'h00, 0, 1, O_DEC,  5);
    add(1, 6'h02, 6'h00, 0, 1, O_J,    5);
    // remaining R-type functs
    add_rtype(6'h24, 3'b000, 6);
    add_rtype(6'h25, 3'b001, 7);
    add_rtype(6'h20, 3'b010, 8);
    add_rtype(6'h22, 3'b110, 9);
    // sw with run dropped after fetch and one store wait: finishes, then IDLE
    add(1, 6'h2b, 6'h00, 0, 1, O_FR,   10);
    add(0, 6'h2b, 6'h00, 0, 1, O_DEC,  10);
    add(0, 6'h2b, 6'h00, 0, 1, O_MADR, 10);
    add(0, 6'h2b, 6'h00, 0, 0, O_MWR,  10);
    add(0, 6'h2b, 6'h00, 0, 1, O_MWR,  10);
    add(0, 6'h2b, 6'h00, 0, 1, O_IDLE, 11);
    add(0, 6'h2b, 6'h00, 0, 1, O_IDLE, 11);

    // Reset state
    rst = 1'b1;
    drive(1, 6'h00, 6'h00, 0, 1);
    #1;
    check("reset_outs", {14'd0, outs()}, 32'd0);
    check("reset_retired", retired, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < n; i++) begin
      drive(tbl[i].run, tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].mr);
      #1;
      check($sformatf("row%0d_outs", i), {14'd0, outs()}, {14'd0, tbl[i].exp});
      check($sformatf("row%0d_retired", i), retired, tbl[i].ret);
      @(negedge clk);
    end

    // Illegal opcode halts and stays halted with run=1
    do_reset();
    step_chk("ill_op_idle",   1, 6'h3f, 6'h00, 0, 1, O_IDLE);
    step_chk("ill_op_fetch",  1, 6'h3f, 6'h00, 0, 1, O_FR);
    step_chk("ill_op_decode", 1, 6'h3f, 6'h00, 0, 1, O_DEC);
    for (int k = 0; k < 3; k++)
      step_chk($sformatf("ill_op_halt%0d", k), 1, 6'h3f, 6'h00, 0, 1, O_HALT);
    #2 rst = 1'b1;
    #1;
    check("ill_op_rst_outs", {14'd0, outs()}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Illegal R-type funct
    do_reset();
    step_chk("ill_fn_idle",   1, 6'h00, 6'h03, 0, 1, O_IDLE);
    step_chk("ill_fn_fetch",  1, 6'h00, 6'h03, 0, 1, O_FR);
    step_chk("ill_fn_decode", 1, 6'h00, 6'h03, 0, 1, O_DEC);
    step_chk("ill_fn_halt0",  1, 6'h00, 6'h03, 0, 1, O_HALT);
    step_chk("ill_fn_halt1",  1, 6'h00, 6'h20, 0, 1, O_HALT);

    // Async reset during a store stall, with a nonzero retire count
    do_reset();
    step_chk("ar_idle",    1, 6'h02, 6'h00, 0, 1, O_IDLE);
    step_chk("ar_j_fetch", 1, 6'h02, 6'h00, 0, 1, O_FR);
    step_chk("ar_j_dec",   1, 6'h02, 6'h00, 0, 1, O_DEC);
    step_chk("ar_j_ex",    1, 6'h02, 6'h00, 0, 1, O_J);
    step_chk("ar_sw_fetch",1, 6'h2b, 6'h00, 0, 1, O_FR);
    step_chk("ar_sw_dec",  1, 6'h2b, 6'h00, 0, 1, O_DEC);
    step_chk("ar_sw_adr",  1, 6'h2b, 6'h00, 0, 1, O_MADR);
    step_chk("ar_sw_st0",  1, 6'h2b, 6'h00, 0, 0, O_MWR);
    drive(1, 6'h2b, 6'h00, 0, 0);
    #1;
    check("ar_sw_st1", {14'd0, outs()}, {14'd0, O_MWR});
    check("ar_retired_pre", retired, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_outs_zero", {14'd0, outs()}, 32'd0);
    check("ar_retired_zero", retired, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Retire counter wrap: preset near the top while in a non-retiring state
    do_reset();
    step_chk("wr_idle", 1, 6'h02, 6'h00, 0, 1, O_IDLE);
    force dut.retired_q = 32'hFFFF_FFFF;
    step_chk("wr_fetch", 1, 6'h02, 6'h00, 0, 1, O_FR);
    release dut.retired_q;
    #1;
    check("wr_preset", retired, 32'hFFFF_FFFF);
    step_chk("wr_dec", 1, 6'h02, 6'h00, 0, 1, O_DEC);
    step_chk("wr_jex", 1, 6'h02, 6'h00, 0, 1, O_J);
    drive(0, 6'h02, 6'h00, 0, 1);
    #1;
    check("wr_wrapped", retired, 32'd0);
    check("wr_next_fetch", {14'd0, outs()}, {14'd0, O_FR});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
